// File: rtl/sram_ext_loader_if.sv
// Command, load-stream, dump-stream and sram external-port signals of sram_ext_loader.
// master = the loader, slave = whoever issues commands and owns the memory.
interface sram_ext_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  logic              busy;
  logic              done;

  logic [DATA_W-1:0] addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [DATA_W-1:0] wdata_ext;
  logic [DATA_W-1:0] rdata_ext;

  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_len,
    input  in_valid, in_data, out_ready, rdata_ext,
    output cmd_ready, in_ready, out_valid, out_data,
    output busy, done, addr_ext, wen_ext, ren_ext, wdata_ext
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_len,
    output in_valid, in_data, out_ready, rdata_ext,
    input  cmd_ready, in_ready, out_valid, out_data,
    input  busy, done, addr_ext, wen_ext, ren_ext, wdata_ext
  );
endinterface

// File: rtl/sram_ext_loader.sv
// Drives the sram external port: loads a valid/ready stream into consecutive words,
// or dumps consecutive words onto a valid/ready stream (1 word per 3 cycles peak).
module sram_ext_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               rst,
  sram_ext_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RD_ISSUE, RD_CAP, RD_OUT, DONE} state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE = 1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W:0]   remain, remain_n;
  logic [DATA_W-1:0] out_data_n, addr_n, wdata_n;
  logic              out_valid_n, busy_n, done_n, wen_n, ren_n;

  function automatic logic [DATA_W-1:0] byte_addr(input logic [ADDR_W-1:0] word);
    logic [DATA_W-1:0] a;
    a = '0;
    a[ADDR_W+1:0] = {word, 2'b00};
    return a;
  endfunction

  assign bus.cmd_ready = (state == IDLE);
  assign bus.in_ready  = (state == LOAD);

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    remain_n   = remain;
    out_data_n = bus.out_data;
    addr_n     = bus.addr_ext;
    wdata_n    = bus.wdata_ext;
    wen_n      = 1'b0;
    ren_n      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          idx_n    = bus.cmd_base;
          remain_n = bus.cmd_len;
          if (bus.cmd_len == '0) state_n = DONE;
          else if (!bus.cmd_op)  state_n = LOAD;
          else                   state_n = RD_ISSUE;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          wen_n    = 1'b1;
          addr_n   = byte_addr(idx);
          wdata_n  = bus.in_data;
          idx_n    = idx + IDX_ONE;
          remain_n = remain - REM_ONE;
          if (remain == REM_ONE) state_n = DONE;
        end
      end
      RD_ISSUE: state_n = RD_CAP;
      RD_CAP: begin
        out_data_n = bus.rdata_ext;
        idx_n      = idx + IDX_ONE;
        remain_n   = remain - REM_ONE;
        state_n    = RD_OUT;
      end
      RD_OUT: begin
        if (bus.out_ready) state_n = (remain != '0) ? RD_ISSUE : DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // The read strobe is registered, so it is raised on entry into RD_ISSUE.
    if (state_n == RD_ISSUE) begin
      ren_n  = 1'b1;
      addr_n = byte_addr(idx_n);
    end
    out_valid_n = (state_n == RD_OUT);
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      remain        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.addr_ext  <= '0;
      bus.wen_ext   <= 1'b0;
      bus.ren_ext   <= 1'b0;
      bus.wdata_ext <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      remain        <= remain_n;
      bus.out_valid <= out_valid_n;
      bus.out_data  <= out_data_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
      bus.addr_ext  <= addr_n;
      bus.wen_ext   <= wen_n;
      bus.ren_ext   <= ren_n;
      bus.wdata_ext <= wdata_n;
    end
  end
endmodule

// File: tb/tb_sram_ext_loader.sv
// Directed bench for sram_ext_loader with a one-cycle-read sram model on the external port.
module tb_sram_ext_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ext_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();
  sram_ext_loader #(.ADDR_W(8), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [256];
  logic        wen_q = 1'b0, ren_q = 1'b0;
  logic [15:0] addr_q = '0, wdata_q = '0;
  int          cyc = 0, wen_cnt = 0, ren_cnt = 0, done_cnt = 0, both_cnt = 0;
  logic [15:0] wen_log[$], ren_log[$], out_log[$];
  int          ren_cyc[$];

  // Bus activity is sampled mid-cycle, the memory then acts on those samples at the edge.
  always @(negedge clk) begin
    cyc++;
    wen_q   = (bus.wen_ext === 1'b1);
    ren_q   = (bus.ren_ext === 1'b1);
    addr_q  = bus.addr_ext;
    wdata_q = bus.wdata_ext;
    if (wen_q) begin wen_cnt++; wen_log.push_back(addr_q); end
    if (ren_q) begin ren_cnt++; ren_log.push_back(addr_q); ren_cyc.push_back(cyc); end
    if (wen_q && ren_q) both_cnt++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) out_log.push_back(bus.out_data);
  end

  always @(posedge clk) begin
    if (wen_q) mem[addr_q[9:2]] <= wdata_q;
    if (ren_q) bus.rdata_ext <= mem[addr_q[9:2]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wen_log.delete(); ren_log.delete(); out_log.delete(); ren_cyc.delete();
  endtask

  task automatic send_cmd(input logic op, input logic [7:0] base, input logic [8:0] len);
    int t = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_base = base; bus.cmd_len = len;
    while (bus.cmd_ready !== 1'b1 && t < 50) begin tick(); t++; end
    check("cmd_accept_timeout", 32'(t < 50), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int t = 0;
    while (bus.done !== 1'b1 && t < budget) begin tick(); t++; end
    check(tag, 32'(t < budget), 32'd1);
    tick();
  endtask

  task automatic load_seq(input logic [7:0] base, input logic [8:0] len,
                          input logic [15:0] d0, input logic [15:0] step);
    send_cmd(1'b0, base, len);
    for (int i = 0; i < 32'(len); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(d0 + step * 16'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    check("load_done_pulse", 32'(bus.done), 32'd1);
    tick();
  endtask

  task automatic dump_seq(input logic [7:0] base, input logic [8:0] len);
    bus.out_ready = 1'b1;
    send_cmd(1'b1, base, len);
    wait_done(3 * 32'(len) + 10, "dump_done_timeout");
  endtask

  initial begin
    int dc, w0, r0, bad;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_addr",      32'(bus.addr_ext),  32'h0);
    check("rst_wen",       32'(bus.wen_ext),   32'd0);
    check("rst_ren",       32'(bus.ren_ext),   32'd0);
    check("rst_wdata",     32'(bus.wdata_ext), 32'h0);
    rst = 1'b0;
    tick();

    // Load base 0x10, len 4, continuous beats, cycle by cycle
    clear_logs(); dc = done_cnt;
    send_cmd(1'b0, 8'h10, 9'd4);
    check("load_in_ready", 32'(bus.in_ready), 32'd1);
    check("load_busy",     32'(bus.busy),     32'd1);
    check("load_cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h1111 * (i + 1));
      tick();
      check("load_wen",   32'(bus.wen_ext),   32'd1);
      check("load_addr",  32'(bus.addr_ext),  32'(16'h040 + 4 * i));
      check("load_wdata", 32'(bus.wdata_ext), 32'(16'h1111 * (i + 1)));
      check("load_done_timing", 32'(bus.done), 32'(i == 3));
    end
    bus.in_valid = 1'b0;
    check("load_in_ready_done", 32'(bus.in_ready), 32'd0);
    tick();
    check("load_wen_after", 32'(bus.wen_ext),   32'd0);
    check("load_done_after", 32'(bus.done),     32'd0);
    check("load_busy_after", 32'(bus.busy),     32'd0);
    check("load_idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("load_done_count", 32'(done_cnt - dc), 32'd1);
    check("load_write_count", 32'(wen_log.size()), 32'd4);

    // Dump the same range with out_ready high
    clear_logs();
    bus.out_ready = 1'b1;
    send_cmd(1'b1, 8'h10, 9'd4);
    check("dump_ren_first",  32'(bus.ren_ext),   32'd1);
    check("dump_addr_first", 32'(bus.addr_ext),  32'h040);
    check("dump_ov_issue",   32'(bus.out_valid), 32'd0);
    tick();
    check("dump_ren_cap",    32'(bus.ren_ext),   32'd0);
    check("dump_ov_cap",     32'(bus.out_valid), 32'd0);
    tick();
    check("dump_ov_latency", 32'(bus.out_valid), 32'd1);
    check("dump_data_first", 32'(bus.out_data),  32'h1111);
    wait_done(20, "dump_done_timeout");
    check("dump_out_count", 32'(out_log.size()), 32'd4);
    check("dump_ren_count", 32'(ren_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < out_log.size()) check("dump_out_data", 32'(out_log[i]), 32'(16'h1111 * (i + 1)));
      if (i < ren_log.size()) check("dump_ren_addr", 32'(ren_log[i]), 32'(16'h040 + 4 * i));
      if (i > 0 && i < ren_cyc.size()) check("dump_ren_spacing", 32'(ren_cyc[i] - ren_cyc[i-1]), 32'd3);
    end

    // Wrap-around load and readback
    clear_logs();
    load_seq(8'hFE, 9'd4, 16'hA000, 16'h0001);
    check("wrap_write_count", 32'(wen_log.size()), 32'd4);
    if (wen_log.size() == 4) begin
      check("wrap_addr0", 32'(wen_log[0]), 32'h3F8);
      check("wrap_addr1", 32'(wen_log[1]), 32'h3FC);
      check("wrap_addr2", 32'(wen_log[2]), 32'h000);
      check("wrap_addr3", 32'(wen_log[3]), 32'h004);
    end
    clear_logs();
    dump_seq(8'hFE, 9'd4);
    check("wrap_out_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < out_log.size()) check("wrap_readback", 32'(out_log[i]), 32'(16'hA000 + i));

    // Dump with 5 stalled cycles per word
    clear_logs();
    bus.out_ready = 1'b0;
    send_cmd(1'b1, 8'h10, 9'd3);
    for (int w = 0; w < 3; w++) begin
      int t = 0;
      while (bus.out_valid !== 1'b1 && t < 10) begin tick(); t++; end
      check("bp_valid_timeout", 32'(t < 10), 32'd1);
      for (int s = 0; s < 5; s++) begin
        check("bp_valid_held", 32'(bus.out_valid), 32'd1);
        check("bp_data_stable", 32'(bus.out_data), 32'(16'h1111 * (w + 1)));
        tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    check("bp_done", 32'(bus.done), 32'd1);
    tick();
    check("bp_ren_count", 32'(ren_log.size()), 32'd3);
    check("bp_out_count", 32'(out_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < out_log.size()) check("bp_out_data", 32'(out_log[i]), 32'(16'h1111 * (i + 1)));

    // Load with gaps in in_valid; a command offered meanwhile must be ignored
    clear_logs();
    send_cmd(1'b0, 8'h20, 9'd2);
    for (int k = 0; k < 4; k++) begin
      bus.in_valid  = (k == 0 || k == 3);
      bus.in_data   = 16'(16'h5000 + k);
      bus.cmd_valid = (k < 3);
      bus.cmd_op    = 1'b1; bus.cmd_base = 8'h00; bus.cmd_len = 9'd1;
      if (k < 3) check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
      check("stall_wen", 32'(bus.wen_ext), 32'(k == 0 || k == 3));
    end
    bus.in_valid = 1'b0; bus.cmd_valid = 1'b0;
    check("stall_done", 32'(bus.done), 32'd1);
    tick();
    check("stall_write_count", 32'(wen_log.size()), 32'd2);
    if (wen_log.size() == 2) check("stall_addr1", 32'(wen_log[1]), 32'h084);
    check("stall_no_read", 32'(ren_log.size()), 32'd0);
    check("stall_mem", 32'(mem[8'h21]), 32'h5003);

    // Zero-length command
    clear_logs();
    send_cmd(1'b0, 8'h40, 9'd0);
    check("len0_done", 32'(bus.done), 32'd1);
    check("len0_wen",  32'(bus.wen_ext), 32'd0);
    tick();
    check("len0_done_clear", 32'(bus.done), 32'd0);
    check("len0_idle", 32'(bus.busy), 32'd0);
    check("len0_no_access", 32'(wen_log.size() + ren_log.size()), 32'd0);

    // Reset after two of four load beats
    clear_logs(); dc = done_cnt;
    send_cmd(1'b0, 8'h30, 9'd4);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h7001 + i);
      tick();
    end
    rst = 1'b1;
    bus.in_data = 16'h7003;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    check("abort_wen",       32'(bus.wen_ext),   32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_in_ready",  32'(bus.in_ready),  32'd0);
    check("abort_addr",      32'(bus.addr_ext),  32'h0);
    repeat (3) tick();
    check("abort_write_count", 32'(wen_log.size()), 32'd2);
    check("abort_no_done", 32'(done_cnt - dc), 32'd0);
    check("abort_last_write", 32'(mem[8'h31]), 32'h7002);

    // Full-memory load and dump
    clear_logs(); w0 = wen_cnt; r0 = ren_cnt;
    load_seq(8'h80, 9'h100, 16'hC000, 16'h0001);
    check("full_write_count", 32'(wen_cnt - w0), 32'd256);
    if (wen_log.size() == 256) begin
      check("full_first_addr", 32'(wen_log[0]),   32'h200);
      check("full_last_addr",  32'(wen_log[255]), 32'h1FC);
    end
    clear_logs();
    dump_seq(8'h00, 9'h100);
    check("full_read_count", 32'(ren_cnt - r0), 32'd256);
    check("full_out_count",  32'(out_log.size()), 32'd256);
    bad = 0;
    for (int j = 0; j < out_log.size(); j++)
      if (out_log[j] !== 16'(16'hC000 + ((j - 32'h80) & 32'hFF))) bad++;
    check("full_readback_errors", 32'(bad), 32'd0);

    check("wen_ren_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_ext_loader.md
# sram_ext_loader

Bus master for the external port (`addr_ext`/`wen_ext`/`ren_ext`/`wdata_ext`/`rdata_ext`) of the banked `sram` instruction/data memories. It accepts a command (load or dump, base word index, word count). Load commands stream words from a valid/ready input into consecutive SRAM words. Dump commands read consecutive SRAM words out onto a valid/ready output. The block is used by the test harness and boot logic to preload program/data memory and to read back results while the CPU drives the primary port.

## Interface
- `ADDR_W`, 8: word-index width of the target `sram`; the memory holds 2^ADDR_W words.
- `DATA_W`, 16: data and byte-address width of the target `sram`; must satisfy DATA_W ≥ ADDR_W+2.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 1: 0 = load (stream→SRAM), 1 = dump (SRAM→stream).
- `cmd_base` in ADDR_W: first word index.
- `cmd_len` in ADDR_W+1: number of words, 0..2^ADDR_W.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DATA_W: load data stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_W: dump data stream.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a command completes.
- `addr_ext` out DATA_W: byte address, equal to {0, word_idx, 2'b00}.
- `wen_ext`, `ren_ext` out 1: write and read strobes to the SRAM external port.
- `wdata_ext` out DATA_W, `rdata_ext` in DATA_W: SRAM external data.

## Operation
- Registers: `state`, `idx` (ADDR_W, current word), `remain` (ADDR_W+1, words left).
- All outputs except `cmd_ready`/`in_ready` are registered.
- States: IDLE, LOAD, RD_ISSUE, RD_CAP, RD_OUT, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch `idx`=cmd_base and `remain`=cmd_len. Next state:
  - cmd_len=0 → DONE.
  - cmd_op=0 → LOAD.
  - cmd_op=1 → RD_ISSUE.
- LOAD: `in_ready`=1 combinationally.
  - Each accepted beat (in_valid&&in_ready at an edge) drives, in the following cycle only, `wen_ext`=1, `addr_ext`=idx<<2, `wdata_ext`=in_data.
  - Each beat then sets idx+=1 (mod 2^ADDR_W) and remain-=1.
  - The beat that makes remain reach 0 moves to DONE.
  - Cycles with in_valid=0 produce `wen_ext`=0.
- RD_ISSUE (1 cycle): `ren_ext`=1 and `addr_ext`=idx<<2 → RD_CAP.
- RD_CAP (1 cycle): `rdata_ext` is valid in this cycle. Capture it into `out_data` at the end of the cycle; set idx+=1 and remain-=1 → RD_OUT.
- RD_OUT: `out_valid`=1 with `out_data` held stable until out_ready. On the handshake, go to RD_ISSUE if remain≠0, else DONE.
- DONE (1 cycle): `done`=1. The final load write, if any, is on the bus in this cycle. Next state is IDLE.
- Index arithmetic wraps modulo 2^ADDR_W. With cmd_len=2^ADDR_W, every word is touched exactly once.
- `wen_ext` and `ren_ext` are never high in the same cycle. Each is high for exactly one cycle per word.
- `cmd_ready`=0 whenever busy, so a command cannot be accepted mid-operation. `in_ready`=0 outside LOAD.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `addr_ext`=0, `wen_ext`=0, `ren_ext`=0, `wdata_ext`=0.
- Load throughput is 1 word/cycle. Each SRAM write occurs 1 cycle after beat acceptance.
- With back-to-back beats, `done` rises the cycle after the last beat is accepted.
- Dump latency is 3 cycles from cmd acceptance (or from the previous out handshake) to `out_valid`. Peak dump rate is 1 word per 3 cycles.
- cmd_len=0: `done` pulses in the cycle after acceptance, with no SRAM access.
- `rst` mid-operation: the state returns to IDLE at that edge and all outputs take their reset values. No further SRAM access occurs, and no `done` is issued for the aborted command.
- A write already on the bus in the cycle `rst` is sampled still completes at that edge.

## Test plan
- Load base=0x10, len=4, data 0x1111/0x2222/0x3333/0x4444 with continuous in_valid → `wen_ext` high 4 consecutive cycles at addr_ext 0x040, 0x044, 0x048, 0x04C. `done` pulses once, in the cycle after the 4th beat.
- Dump of the same range with out_ready=1 → out_data 0x1111, 0x2222, 0x3333, 0x4444 in order. `ren_ext` pulses at 0x040..0x04C spaced 3 cycles apart.
- Wrap: load base=0xFE, len=4 → writes at byte addresses 0x3F8, 0x3FC, 0x000, 0x004. Dump readback matches.
- Backpressure: dump with out_ready low for 5 cycles per word → out_data is stable while stalled, there are no extra `ren_ext` pulses, and no words are lost or duplicated.
- Stalled load: in_valid toggling 1,0,0,1 → exactly one `wen_ext` per accepted beat and none in gap cycles. cmd_valid during busy is not accepted.
- cmd_len=0 → `done` in the next cycle, no `wen_ext`/`ren_ext`. `rst` asserted after 2 of 4 load beats → exactly 2 writes occur, IDLE afterwards, `done` stays 0.
